// File: rtl/pcb_reset_pkg.sv
// ============================================================================
// Module   : pcb_reset_pkg
// Brief    : Shared types and default timing constants for the PCB reset driver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcb_reset_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int c_DEFAULT_PULSE_CYCLES   = 1_000_000;
  localparam int c_DEFAULT_HOLDOFF_CYCLES = 1_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_edge_det.sv
// ============================================================================
// Module   : req_edge_det
// Brief    : Rising-edge detector for the reset request against its sampled history
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic enable,
  output logic rise
);

  logic r_prev;

  // History resets high so a request already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= in;
    end
  end

  assign rise = enable & in & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pcb_reset_driver.sv
// ============================================================================
// Module   : pcb_reset_driver
// Brief    : Generates a timed board reset pulse followed by a recovery holdoff
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcb_reset_driver
  import pcb_reset_pkg::*;
#(
  parameter int PULSE_CYCLES   = c_DEFAULT_PULSE_CYCLES,
  parameter int HOLDOFF_CYCLES = c_DEFAULT_HOLDOFF_CYCLES,
  parameter bit POR_PULSE      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic PCB_RST,
  output logic busy,
  output logic done,
  output logic req_dropped
);

  localparam int c_CNT_W = $clog2(max_int(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLDOFF_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_next_cnt;
  logic                 r_por_pending;
  logic                 r_pcb_rst;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_req_dropped;
  logic                 w_rise;
  logic                 w_start;

  req_edge_det u_req_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (req),
    .enable (1'b1),
    .rise   (w_rise)
  );

  // The power-on request behaves exactly like a request edge on the first clock.
  assign w_start = w_rise | r_por_pending;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = '0;
    case (r_state)
      IDLE:    if (w_start)                w_next_state = ASSERT;
      ASSERT:  if (r_cnt == c_PULSE_LAST)  w_next_state = HOLD;
      HOLD:    if (r_cnt == c_HOLD_LAST)   w_next_state = IDLE;
      default:                             w_next_state = IDLE;
    endcase
    if ((w_next_state == r_state) && (r_state != IDLE)) begin
      w_next_cnt = r_cnt + c_CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_por_pending <= POR_PULSE;
      r_pcb_rst     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_req_dropped <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_por_pending <= 1'b0;
      r_pcb_rst     <= (w_next_state == ASSERT);
      r_busy        <= (w_next_state != IDLE);
      r_done        <= (r_state == HOLD) && (w_next_state == IDLE);
      r_req_dropped <= w_rise && (r_state != IDLE);
    end
  end

  assign PCB_RST     = r_pcb_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign req_dropped = r_req_dropped;

endmodule

`default_nettype wire

// File: tb/tb_pcb_reset_driver.sv
// ============================================================================
// Module   : tb_pcb_reset_driver
// Brief    : Self-checking bench for pcb_reset_driver (directed tables plus random vs model)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcb_reset_driver;

  localparam int c_P = 4;
  localparam int c_H = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req, pcb_rst, busy, done, req_dropped;
  logic rst_n_p, req_p, pcb_rst_p, busy_p, done_p, dropped_p;

  pcb_reset_driver #(.PULSE_CYCLES(c_P), .HOLDOFF_CYCLES(c_H), .POR_PULSE(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .PCB_RST     (pcb_rst),
    .busy        (busy),
    .done        (done),
    .req_dropped (req_dropped)
  );

  pcb_reset_driver #(.PULSE_CYCLES(c_P), .HOLDOFF_CYCLES(c_H), .POR_PULSE(1'b1)) dut_por (
    .clk         (clk),
    .rst_n       (rst_n_p),
    .req         (req_p),
    .PCB_RST     (pcb_rst_p),
    .busy        (busy_p),
    .done        (done_p),
    .req_dropped (dropped_p)
  );

  typedef struct {
    logic       req;
    logic [3:0] exp;   // {PCB_RST, busy, done, req_dropped}
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: m_t = cycles since the pulse began, -1 when idle.
  int   m_t;
  logic m_prev;

  function automatic logic [3:0] outs();
    return {pcb_rst, busy, done, req_dropped};
  endfunction

  function automatic logic [3:0] outs_p();
    return {pcb_rst_p, busy_p, done_p, dropped_p};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: pcb/busy/done/drop got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] e, input int n);
    repeat (n) tbl.push_back('{req: r, exp: e});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_step(input logic r, output logic [3:0] e);
    logic edge_seen, exp_done, exp_drop;
    edge_seen = r && !m_prev;
    m_prev    = r;
    exp_done  = 1'b0;
    exp_drop  = 1'b0;
    if (m_t >= 0) begin
      exp_drop = edge_seen;
      m_t++;
      if (m_t == c_P + c_H) begin
        m_t      = -1;
        exp_done = 1'b1;
      end
    end else if (edge_seen) begin
      m_t = 0;
    end
    e = {(m_t >= 0) && (m_t < c_P), (m_t >= 0), exp_done, exp_drop};
  endtask

  initial begin
    int pcb_n, busy_n, drop_n, done_n;
    logic [3:0] e;

    rst_n   = 1'b0;
    req     = 1'b0;
    rst_n_p = 1'b0;
    req_p   = 1'b0;
    repeat (3) tick();
    chk("reset_state", outs(), 4'b0000);
    chk("reset_state_por", outs_p(), 4'b0000);

    // Automatic power-on pulse.
    rst_n_p = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("por_cycle%0d", k), outs_p(), {k <= c_P, k <= c_P + c_H, k == c_P + c_H + 1, 1'b0});
    end

    // Single request, then a new request landing in the done cycle.
    add(1'b0, 4'b0000, 5);
    add(1'b1, 4'b1100, 2);
    add(1'b0, 4'b1100, 2);
    add(1'b0, 4'b0100, 10);
    add(1'b0, 4'b0010, 1);
    add(1'b1, 4'b1100, 4);
    add(1'b0, 4'b0100, 1);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("table_edge%0d", i + 1), outs(), tbl[i].exp);
    end

    // Extra request edges during ASSERT and HOLD must not stretch anything.
    do_reset();
    pcb_n = 0; busy_n = 0; drop_n = 0; done_n = 0;
    for (int c = 1; c <= 30; c++) begin
      req = (c == 3) || (c == 4) || (c == 6) || (c == 12);
      tick();
      pcb_n  += int'(pcb_rst);
      busy_n += int'(busy);
      drop_n += int'(req_dropped);
      done_n += int'(done);
    end
    chk_int("retrigger_pcb_width", pcb_n, c_P);
    chk_int("retrigger_busy_width", busy_n, c_P + c_H);
    chk_int("retrigger_dropped", drop_n, 2);
    chk_int("retrigger_done", done_n, 1);

    // Asynchronous abort in the second ASSERT cycle, req held high through release.
    do_reset();
    tick();
    req = 1'b1;
    tick();
    tick();
    chk("abort_pre", outs(), 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", outs(), 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    pcb_n = 0; busy_n = 0; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      pcb_n  += int'(pcb_rst);
      busy_n += int'(busy);
      done_n += int'(done);
    end
    chk_int("abort_no_pulse", pcb_n, 0);
    chk_int("abort_no_busy", busy_n, 0);
    chk_int("abort_no_done", done_n, 0);

    // Random request traffic with occasional asynchronous resets.
    do_reset();
    m_t    = -1;
    m_prev = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2;
        chk("random_async_reset", outs(), 4'b0000);
        tick();
        rst_n  = 1'b1;
        m_t    = -1;
        m_prev = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) req = ~req;
      model_step(req, e);
      tick();
      chk("random", outs(), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcb_reset_driver.md
PCB_RESET_DRIVER -- requirements
Module: pcb_reset_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 1_000_000: PCB_RST high time in clk cycles; legal range >= 1.
REQ-002 Parameter HOLDOFF_CYCLES, default 1_000_000: post-pulse recovery window in clk cycles; legal range >= 1.
REQ-003 Parameter POR_PULSE, default 1: 1 = issue one pulse automatically after reset release; 0 = no automatic pulse.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  reset request, level; only a rising edge is honoured.
REQ-007 PCB_RST  output  1  board reset line, active-high pulse; registered.
REQ-008 busy  output  1  high while a pulse or holdoff is in progress; registered.
REQ-009 done  output  1  one-cycle pulse when holdoff completes; registered.
REQ-010 req_dropped  output  1  one-cycle pulse when a req rising edge is ignored; registered.

Function
REQ-011 FSM states SHALL be IDLE, ASSERT, HOLD.
REQ-012 Request edge = req high in the current cycle and low in the previous cycle, as sampled by clk.
REQ-013 IDLE -> ASSERT on a request edge; PCB_RST and busy go high on the same clock edge that detects the request edge (1-cycle latency from req sampled high).
REQ-014 In ASSERT, PCB_RST SHALL be high for exactly PULSE_CYCLES consecutive cycles, then the FSM moves to HOLD.
REQ-015 In HOLD, PCB_RST SHALL be low and busy high for exactly HOLDOFF_CYCLES cycles, then the FSM moves to IDLE.
REQ-016 done SHALL pulse for one cycle, coincident with the first IDLE cycle after HOLD; busy is low in that cycle.
REQ-017 A request edge in ASSERT or HOLD SHALL NOT restart or extend the pulse; req_dropped pulses for one cycle on the following clock edge.
REQ-018 A request edge in the same cycle the FSM returns to IDLE (done cycle) SHALL be accepted and start a new pulse.
REQ-019 Cycle counter width = $clog2(max(PULSE_CYCLES,HOLDOFF_CYCLES)+1); it loads 0 on each state entry; wrap-around SHALL never occur.
REQ-020 busy SHALL equal (state != IDLE) registered; PCB_RST SHALL equal (state == ASSERT) registered; both are glitch-free.

Reset
REQ-021 While rst_n is low: PCB_RST=0, busy=0, done=0, req_dropped=0, state=IDLE, counter=0, previous-req register=1.
REQ-022 A req already high at reset release SHALL NOT count as an edge.
REQ-023 With POR_PULSE=1, the first clk edge after rst_n deasserts SHALL enter ASSERT as if a request edge occurred; with POR_PULSE=0 the FSM stays IDLE.
REQ-024 rst_n asserted mid-pulse or mid-holdoff SHALL abort immediately (asynchronously) to the reset values; no done pulse is generated.

Structure
REQ-025 Package pcb_reset_pkg SHALL hold the state enum typedef and the default PULSE_CYCLES / HOLDOFF_CYCLES constants.
REQ-026 One sub-module, req_edge_det (clk, rst_n, in, enable, rise), SHALL provide the registered request-edge detection with async active-low reset.
REQ-027 FSM, counter and output registers SHALL reside in pcb_reset_driver; no other sub-modules.

Verification (PULSE_CYCLES=4, HOLDOFF_CYCLES=10)
REQ-028 POR_PULSE=1, release rst_n -> PCB_RST high cycles 1-4, busy high cycles 1-14, done pulse at cycle 15.
REQ-029 POR_PULSE=0, req low->high at cycle 5 -> PCB_RST high cycles 6-9, done at cycle 20, req_dropped never asserted.
REQ-030 Second req edge during ASSERT and another during HOLD -> PCB_RST width stays 4, busy width stays 14, req_dropped pulses once per edge.
REQ-031 req edge in the done cycle -> new PCB_RST pulse starts the next cycle; busy returns high after one low cycle.
REQ-032 rst_n pulled low at the 2nd ASSERT cycle -> PCB_RST/busy drop without a clock; no done; req held high through release -> no pulse (POR_PULSE=0).
